// File: rtl/canvas_capture.sv
`default_nettype none
// ============================================================================
//  Module   : canvas_capture
//  Purpose  : 32x32 binary drawing canvas with pen write/erase, sequential
//             row-by-row clear, running ink count and a frozen snapshot
//             presented to the image path through a valid/ack handshake.
//  Revision : 1.0  initial release
// ============================================================================
module canvas_capture #(
    parameter int MIN_INK  = 8,
    parameter int CLR_ROWS = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pen_valid,
    input  logic [4:0]    pen_x,
    input  logic [4:0]    pen_y,
    input  logic          pen_erase,
    input  logic          clear_req,
    input  logic          snap_req,
    input  logic          image_ack,
    output logic [1023:0] canvas,
    output logic [1023:0] image_out,
    output logic          image_valid,
    output logic          snap_reject,
    output logic          busy,
    output logic [10:0]   ink_count
);

    localparam logic [10:0] c_MIN_INK  = 11'(MIN_INK);
    localparam logic [4:0]  c_LAST_ROW = 5'(CLR_ROWS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [1023:0] r_canvas;
    logic [1023:0] r_image;
    logic          r_image_valid;
    logic          r_snap_reject;
    logic [10:0]   r_ink;
    logic [4:0]    r_row;

    logic [9:0]    w_pix_idx;
    logic          w_pix_old;
    logic          w_pen_we;
    logic          w_snap_ok;
    logic          w_snap_rej;
    logic          w_clear_start;
    logic          w_clear_last;
    logic [31:0]   w_row_bits;
    logic [5:0]    w_row_pop;

    // Row-major pixel index: row in the upper five bits, column in the lower.
    assign w_pix_idx  = {pen_y, pen_x};
    assign w_pix_old  = r_canvas[w_pix_idx];
    assign w_row_bits = r_canvas[{r_row, 5'd0} +: 32];

    // Population count of the row being swept, removed from the ink count.
    always_comb begin
        w_row_pop = '0;
        for (int i = 0; i < 32; i++) begin
            w_row_pop = w_row_pop + {5'd0, w_row_bits[i]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle decisions; clear beats a same-cycle pen event,
    // and snapshots are considered only while idle with no frame outstanding.
    always_comb begin
        w_state_nxt   = r_state;
        w_clear_start = 1'b0;
        w_clear_last  = 1'b0;
        w_pen_we      = 1'b0;
        w_snap_ok     = 1'b0;
        w_snap_rej    = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt   = CLEAR;
                    w_clear_start = 1'b1;
                end else if (pen_valid) begin
                    w_pen_we = 1'b1;
                end
                if (snap_req && !r_image_valid) begin
                    if (r_ink >= c_MIN_INK) begin
                        w_snap_ok = 1'b1;
                    end else begin
                        w_snap_rej = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (r_row == c_LAST_ROW) begin
                    w_state_nxt  = IDLE;
                    w_clear_last = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Canvas, row counter and ink count; the count tracks only real bit flips.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_canvas <= '0;
            r_row    <= '0;
            r_ink    <= '0;
        end else if (w_clear_start) begin
            r_row <= '0;
        end else if (r_state == CLEAR) begin
            r_canvas[{r_row, 5'd0} +: 32] <= '0;
            r_row <= r_row + 5'd1;
            if (w_clear_last) begin
                r_ink <= '0;
            end else begin
                r_ink <= r_ink - {5'd0, w_row_pop};
            end
        end else if (w_pen_we) begin
            r_canvas[w_pix_idx] <= ~pen_erase;
            if (!pen_erase && !w_pix_old) begin
                r_ink <= r_ink + 11'd1;
            end else if (pen_erase && w_pix_old) begin
                r_ink <= r_ink - 11'd1;
            end
        end
    end

    // Snapshot capture and handshake; the frame holds until ack is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_image       <= '0;
            r_image_valid <= 1'b0;
            r_snap_reject <= 1'b0;
        end else begin
            r_snap_reject <= w_snap_rej;
            if (w_snap_ok) begin
                r_image       <= r_canvas;
                r_image_valid <= 1'b1;
            end else if (r_image_valid && image_ack) begin
                r_image_valid <= 1'b0;
            end
        end
    end

    assign canvas      = r_canvas;
    assign image_out   = r_image;
    assign image_valid = r_image_valid;
    assign snap_reject = r_snap_reject;
    assign busy        = (r_state == CLEAR);
    assign ink_count   = r_ink;

endmodule
`default_nettype wire

// File: tb/tb_canvas_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_canvas_capture
//  Purpose  : Directed self-checking bench for canvas_capture. A behavioural
//             model predicts every output after each clock; predictions are
//             queued and compared when the cycle completes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_canvas_capture;

    localparam int c_MIN_INK = 8;

    logic          clk = 1'b0;
    logic          rst, pen_valid, pen_erase, clear_req, snap_req, image_ack;
    logic [4:0]    pen_x, pen_y;
    logic [1023:0] canvas, image_out;
    logic          image_valid, snap_reject, busy;
    logic [10:0]   ink_count;

    always #5 clk = ~clk;

    canvas_capture #(.MIN_INK(c_MIN_INK), .CLR_ROWS(32)) dut (
        .clk(clk), .rst(rst),
        .pen_valid(pen_valid), .pen_x(pen_x), .pen_y(pen_y), .pen_erase(pen_erase),
        .clear_req(clear_req), .snap_req(snap_req), .image_ack(image_ack),
        .canvas(canvas), .image_out(image_out), .image_valid(image_valid),
        .snap_reject(snap_reject), .busy(busy), .ink_count(ink_count)
    );

    typedef struct {
        logic [1023:0] cv;
        logic [1023:0] img;
        logic          vld;
        logic          rej;
        logic          bsy;
        logic [10:0]   ink;
    } exp_t;

    exp_t          sb[$];
    logic [1023:0] m_cv, m_img;
    logic          m_vld, m_rej, m_clr;
    int            m_row;
    int            checks = 0;
    int            errors = 0;
    int            busy_cnt;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk11(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1024(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int first;
        first = -1;
        for (int i = 1023; i >= 0; i--) begin
            if (obs[i] !== exp[i]) first = i;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed ones=%0d expected ones=%0d first_diff_bit=%0d",
                   tag, $countones(obs), $countones(exp), first);
        end
    endtask

    // Predict the post-edge outputs from the inputs currently driven.
    task automatic push_expect();
        exp_t       e;
        logic [9:0] idx;
        if (rst) begin
            m_cv = '0; m_img = '0; m_vld = 1'b0; m_rej = 1'b0; m_clr = 1'b0; m_row = 0;
        end else begin
            m_rej = 1'b0;
            if (!m_clr) begin
                if (snap_req && !m_vld) begin
                    if ($countones(m_cv) >= c_MIN_INK) begin
                        m_img = m_cv;
                        m_vld = 1'b1;
                    end else begin
                        m_rej = 1'b1;
                    end
                end else if (m_vld && image_ack) begin
                    m_vld = 1'b0;
                end
                if (clear_req) begin
                    m_clr = 1'b1;
                    m_row = 0;
                end else if (pen_valid) begin
                    idx = {pen_y, pen_x};
                    m_cv[idx] = ~pen_erase;
                end
            end else begin
                if (m_vld && image_ack) m_vld = 1'b0;
                m_cv[m_row*32 +: 32] = '0;
                if (m_row == 31) begin
                    m_clr = 1'b0;
                    m_row = 0;
                end else begin
                    m_row++;
                end
            end
        end
        e.cv  = m_cv;
        e.img = m_img;
        e.vld = m_vld;
        e.rej = m_rej;
        e.bsy = m_clr;
        e.ink = 11'($countones(m_cv));
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        push_expect();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk1024("canvas", canvas, e.cv);
        chk1024("image_out", image_out, e.img);
        chk1("image_valid", image_valid, e.vld);
        chk1("snap_reject", snap_reject, e.rej);
        chk1("busy", busy, e.bsy);
        chk11("ink_count", ink_count, e.ink);
    endtask

    task automatic idle();
        rst = 1'b0; pen_valid = 1'b0; pen_erase = 1'b0; pen_x = '0; pen_y = '0;
        clear_req = 1'b0; snap_req = 1'b0; image_ack = 1'b0;
    endtask

    task automatic pen(input int x, input int y, input logic er);
        pen_valid = 1'b1; pen_x = 5'(x); pen_y = 5'(y); pen_erase = er;
        cycle();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        idle();
        chk11("reset_ink", ink_count, 11'd0);
        chk1("reset_busy", busy, 1'b0);

        // Corner pixels.
        pen(3, 0, 1'b0);
        pen(0, 31, 1'b0);
        pen(31, 31, 1'b0);
        chk11("ink_three", ink_count, 11'd3);
        chk1("bit3", canvas[3], 1'b1);
        chk1("bit992", canvas[992], 1'b1);
        chk1("bit1023", canvas[1023], 1'b1);

        // Redundant set/erase must not move the count.
        pen(5, 5, 1'b0); chk11("set55_a", ink_count, 11'd4);
        pen(5, 5, 1'b0); chk11("set55_b", ink_count, 11'd4);
        chk1("bit165_set", canvas[165], 1'b1);
        pen(5, 5, 1'b1); chk11("erase55_a", ink_count, 11'd3);
        chk1("bit165_clr", canvas[165], 1'b0);
        pen(5, 5, 1'b1); chk11("erase55_b", ink_count, 11'd3);

        // Five pixels: rejected, single-cycle pulse.
        pen(10, 1, 1'b0);
        pen(11, 1, 1'b0);
        snap_req = 1'b1; cycle(); idle();
        chk1("reject5_pulse", snap_reject, 1'b1);
        cycle();
        chk1("reject5_drop", snap_reject, 1'b0);
        chk1("reject5_novalid", image_valid, 1'b0);

        // Seven pixels: just below threshold.
        pen(12, 1, 1'b0);
        pen(13, 1, 1'b0);
        snap_req = 1'b1; cycle(); idle();
        chk1("reject7_pulse", snap_reject, 1'b1);
        cycle();

        // Eight pixels: exactly at threshold, accepted.
        pen(14, 1, 1'b0);
        snap_req = 1'b1; cycle(); idle();
        chk1("accept8_valid", image_valid, 1'b1);
        chk1("accept8_norej", snap_reject, 1'b0);
        image_ack = 1'b1; cycle(); idle();
        chk1("accept8_acked", image_valid, 1'b0);

        // Ten more pixels, then snapshot with a same-cycle pen write.
        for (int i = 0; i < 10; i++) pen(i, 10, 1'b0);
        snap_req = 1'b1; pen_valid = 1'b1; pen_x = 5'd20; pen_y = 5'd20;
        cycle(); idle();
        chk1("snap_excl_pen", image_out[660], 1'b0);
        chk1("canvas_has_pen", canvas[660], 1'b1);
        pen(0, 0, 1'b0);
        chk1("img_stable_00", image_out[0], 1'b0);
        for (int i = 0; i < 20; i++) begin
            snap_req = (i == 5);
            cycle();
            idle();
        end
        chk1("held_20", image_valid, 1'b1);
        image_ack = 1'b1; snap_req = 1'b1; cycle(); idle();
        chk1("ack_drop", image_valid, 1'b0);
        cycle();
        chk1("ack_snap_ignored", image_valid, 1'b0);

        // Fill more ink, hold a snapshot, then sweep with ack mid-sweep.
        for (int i = 0; i < 30; i++) pen(i, 25, 1'b0);
        snap_req = 1'b1; cycle(); idle();
        chk1("pre_clear_valid", image_valid, 1'b1);
        clear_req = 1'b1; pen_valid = 1'b1; pen_x = 5'd1; pen_y = 5'd1;
        cycle(); idle();
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            pen_valid = (i < 32);
            pen_x     = 5'(i);
            pen_y     = 5'(i);
            snap_req  = (i == 8);
            clear_req = (i == 12);
            image_ack = (i == 4);
            cycle();
            idle();
        end
        chk11("busy_cycles", 11'(busy_cnt), 11'd32);
        chk11("clear_ink", ink_count, 11'd0);
        chk1("clear_11_unwritten", canvas[33], 1'b0);
        chk1("ack_in_clear", image_valid, 1'b0);

        // Reset in the middle of a sweep.
        pen(2, 3, 1'b0);
        pen(7, 9, 1'b0);
        clear_req = 1'b1; cycle(); idle();
        for (int i = 0; i < 9; i++) cycle();
        rst = 1'b1; cycle(); idle();
        chk1("rst_busy", busy, 1'b0);
        chk11("rst_ink", ink_count, 11'd0);
        pen(2, 2, 1'b0);
        chk11("post_rst_pen", ink_count, 11'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
